// File: rtl/regfile_pkg.sv
// Shared widths and types for the Lab5 register file.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// Write-address decoder: one-hot register select, all zero when wr_en is low.
module regfile_wr_decoder #(
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
)(
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_reg,
   output logic [NUM_REGS-1:0] wr_sel
);

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_reg == ADDR_W'(gi));
   end

endmodule

// File: rtl/reg_file32.sv
// reg_file32: 32 x 32-bit register file, one write port, two registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file32 #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int R0_ZERO  = 1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_reg,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_reg1,
   input  logic [ADDR_W-1:0] rd_reg2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_valid
);
   import regfile_pkg::*;

   logic [NUM_REGS-1:0] wr_sel;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   rd_data1_q, rd_data2_q, rd_data1_d, rd_data2_d;
   logic                rd_valid_q;

   regfile_wr_decoder #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_wr_decoder (
      .wr_en  (wr_en),
      .wr_reg (wr_reg),
      .wr_sel (wr_sel)
   );

   // Asynchronous clear forces flops for storage rather than a RAM macro.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i] && !(R0_ZERO != 0 && i == 0)) regs_q[i] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data1_d = regs_q[rd_reg1];
      rd_data2_d = regs_q[rd_reg2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_reg == rd_reg1) rd_data1_d = wr_data;
      if (wr_en && wr_reg == rd_reg2) rd_data2_d = wr_data;
`endif
      if (R0_ZERO != 0 && rd_reg1 == '0) rd_data1_d = '0;
      if (R0_ZERO != 0 && rd_reg2 == '0) rd_data2_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data1_q <= '0;
         rd_data2_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
         end
      end
   end

   assign rd_data1 = rd_data1_q;
   assign rd_data2 = rd_data2_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- 32-entry x 32-bit register file for the Lab5 datapath.
- One write port: one-hot write enable from a 5-to-32 address decode.
- Two synchronous read ports: 32:1 read-address selection; read data is registered one cycle later.
- Sits between the instruction-decode stage, which supplies register numbers, and the ALU, which consumes the read operands.

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of registers; must be a power of 2.
- ADDR_W, 5: register-number width; must equal log2(NUM_REGS).
- R0_ZERO, 1: 1 = register 0 is hardwired to zero and writes to it are discarded; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe.
- wr_reg  input  ADDR_W  destination register number.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request for both ports.
- rd_reg1  input  ADDR_W  register number for port 1.
- rd_reg2  input  ADDR_W  register number for port 2.
- rd_data1  output  DATA_W  registered read data, port 1.
- rd_data2  output  DATA_W  registered read data, port 2.
- rd_valid  output  1  rd_data1/rd_data2 hold fresh data this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset (reset_n=0):
  - Immediately clears all NUM_REGS registers, rd_data1, rd_data2 and rd_valid to 0.
  - Holds them at 0 while reset_n is low, independent of clk.
  - Operation resumes on the first rising edge of clk after reset_n deasserts.
- Reset mid-operation: a read or write in flight when reset_n asserts is dropped, and rd_valid drops immediately. No partial update survives.
- Write:
  - At a rising edge with wr_en=1, the register selected by the one-hot decode of wr_reg takes wr_data.
  - Exactly one register is updated per write.
  - wr_en=0: no register changes.
- Register 0: when R0_ZERO=1, a write to register 0 is ignored and reads of register 0 always return 0.
- Read latency: 1 cycle.
  - At a rising edge with rd_en=1, rd_data1/rd_data2 load the stored contents of rd_reg1/rd_reg2, and rd_valid is set to 1.
  - With rd_en=0, rd_valid is cleared to 0 and rd_data1/rd_data2 hold their previous values.
- rd_valid is a single-cycle strobe per request. Back-to-back rd_en produces back-to-back valid data with no bubble.
- Same-address reads: rd_reg1 == rd_reg2 is legal; both ports return the same value.
- Simultaneous read and write of the same register in one cycle (without the Optional Feature): the read returns the OLD value (read-before-write). The new value is visible to a read issued on the next cycle.
- Simultaneous write and read of different registers: fully independent.
- No storage state machine. Only state is the register array plus the output registers and rd_valid.
- Widths: wr_reg, rd_reg1 and rd_reg2 are full-range. Every value 0 to NUM_REGS-1 is a valid register number; there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: when rd_en=1, wr_en=1 and rd_regN == wr_reg in the same cycle, rd_dataN loads wr_data (write-through forwarding).
  - Applies per port independently.
  - Exception: when R0_ZERO=1 and the register is 0, the port still returns 0.
- Undefined: read-before-write as described in Behaviour.
- The register-array update is identical in both builds.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, NUM_REGS=32, ADDR_W=5;
  - typedef reg_addr_t (ADDR_W bits);
  - typedef reg_data_t (DATA_W bits).
- One sub-module, regfile_wr_decoder:
  - ADDR_W-to-NUM_REGS one-hot decoder gated by wr_en;
  - all-zero output when wr_en=0.
- Read selection is done inline in reg_file32.

Test Plan:
- Reset: preload r5=32'hDEAD_BEEF, assert reset_n=0 between clock edges -> rd_valid=0 and rd_data1/rd_data2=0 at once; a later read of r5 returns 0.
- Write/read: write r7=32'h1234_5678, next cycle rd_en with rd_reg1=7, rd_reg2=7 -> one cycle later rd_data1=rd_data2=32'h1234_5678, rd_valid=1 for exactly one cycle.
- Register 0: write r0=32'hFFFF_FFFF, then read r0 -> rd_data1=0 with R0_ZERO=1; with R0_ZERO=0 -> 32'hFFFF_FFFF.
- Same-cycle collision: r3=32'h0000_0001, then in one cycle write r3=32'h0000_0002 and read r3 -> rd_data1=32'h1 without REGFILE_BYPASS_EN, 32'h2 with it; a read on the following cycle returns 32'h2 in both builds.
- Sweep: write r_i=i for i=1..31, then back-to-back reads with rd_reg1=i, rd_reg2=31-i -> rd_data1=i and rd_data2=31-i every cycle, rd_valid held high throughout, no bubbles.
- Hold: rd_en=0 after a read of r7 -> rd_valid=0 and rd_data1 keeps 32'h1234_5678 while r7 is overwritten to 32'h0.
